// File: rtl/seg_scan_pkg.sv
// Shared types and width helpers for the 7-segment display scanner.
package seg_scan_pkg;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot/digit counters for the scanner; blank_phase describes the slot position
// the counters move to on the coming edge so the top can register aligned outputs.
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic [idx_width(NUM_DIGITS)-1:0]    digit_idx,
    output logic                                slot_last,
    output logic                                frame_last,
    output logic                                blank_phase
);

    localparam int CW = cnt_width(REFRESH_DIV);
    localparam int DW = idx_width(NUM_DIGITS);

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] slot_nxt;
    phase_t        phase_nxt;

    assign slot_last   = (slot_cnt == CW'(REFRESH_DIV - 1));
    assign frame_last  = slot_last && (digit_idx == DW'(NUM_DIGITS - 1));
    assign blank_phase = (phase_nxt == PH_BLANK);

    always_comb begin
        slot_nxt  = slot_last ? '0 : slot_cnt + CW'(1);
        phase_nxt = (slot_nxt < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_nxt;
            if (frame_last) begin
                digit_idx <= '0;
            end else if (slot_last) begin
                digit_idx <= digit_idx + DW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 7-seg scanner: shadow register applied only at frame boundaries.
// Outputs registered from next-state values (no added latency); load is always accepted.
module seg_display_scanner
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dot_in,
    input  logic [NUM_DIGITS-1:0]     digit_mask,
    output logic [3:0]                hex_out,
    output logic                      dot_out,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_start,
    output logic                      update_pending
);

    localparam int DW = idx_width(NUM_DIGITS);

    logic [DW-1:0]             digit_idx;
    logic [DW-1:0]             digit_nxt;
    logic                      slot_last;
    logic                      frame_last;
    logic                      blank_phase;

    logic [4*NUM_DIGITS-1:0]   act_value, act_value_nxt, shd_value;
    logic [NUM_DIGITS-1:0]     act_dot, act_dot_nxt, shd_dot;
    logic [NUM_DIGITS-1:0]     act_mask, act_mask_nxt, shd_mask;
    logic [NUM_DIGITS-1:0]     en_sel;

    seg_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .digit_idx   (digit_idx),
        .slot_last   (slot_last),
        .frame_last  (frame_last),
        .blank_phase (blank_phase)
    );

    // A load coinciding with the boundary bypasses the shadow so it is not a frame late.
    always_comb begin
        act_value_nxt = act_value;
        act_dot_nxt   = act_dot;
        act_mask_nxt  = act_mask;
        if (frame_last) begin
            if (load) begin
                act_value_nxt = value_in;
                act_dot_nxt   = dot_in;
                act_mask_nxt  = digit_mask;
            end else if (update_pending) begin
                act_value_nxt = shd_value;
                act_dot_nxt   = shd_dot;
                act_mask_nxt  = shd_mask;
            end
        end
    end

    always_comb begin
        if (frame_last) begin
            digit_nxt = '0;
        end else if (slot_last) begin
            digit_nxt = digit_idx + DW'(1);
        end else begin
            digit_nxt = digit_idx;
        end
        en_sel            = '0;
        en_sel[digit_nxt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_value      <= '0;
            act_dot        <= '0;
            act_mask       <= '0;
            shd_value      <= '0;
            shd_dot        <= '0;
            shd_mask       <= '0;
            update_pending <= 1'b0;
            hex_out        <= '0;
            dot_out        <= 1'b0;
            digit_en       <= '0;
            frame_start    <= 1'b0;
        end else begin
            act_value <= act_value_nxt;
            act_dot   <= act_dot_nxt;
            act_mask  <= act_mask_nxt;
            if (load) begin
                shd_value <= value_in;
                shd_dot   <= dot_in;
                shd_mask  <= digit_mask;
            end
            update_pending <= frame_last ? 1'b0 : (load | update_pending);
            hex_out        <= act_value_nxt[{digit_nxt, 2'b00} +: 4];
            dot_out        <= act_dot_nxt[digit_nxt];
            digit_en       <= blank_phase ? '0 : (en_sel & act_mask_nxt);
            frame_start    <= frame_last;
        end
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Time-multiplexed scanner for a multi-digit common-segment 7-segment display. Sits directly upstream of the hex-to-7-segment decoder: it drives the decoder's 4-bit hex input and dot, and produces the one-hot digit enables. A shadow register accepts new display values at any time. New values become visible only at a frame boundary, so a frame is never torn. A blanking gap at the start of each digit slot prevents ghosting.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 1000, clock cycles per digit slot, including blanking (>= BLANK_CYCLES+2)
BLANK_CYCLES, 16, cycles at start of each slot with all digit enables low (>= 1)

Ports:
clk  input  1  single system clock; one clock domain
reset  input  1  synchronous, active-high reset
load  input  1  1-cycle strobe; capture value_in/dot_in/digit_mask
value_in  input  4*NUM_DIGITS  hex nibbles; nibble k = bits [4k+3:4k] = digit k
dot_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
digit_mask  input  NUM_DIGITS  1 = digit enabled, 0 = digit kept dark
hex_out  output  4  nibble to the 7-seg decoder input
dot_out  output  1  dot to the decoder
digit_en  output  NUM_DIGITS  one-hot active-high digit select
frame_start  output  1  1-cycle pulse when digit 0's slot begins after a wrap
update_pending  output  1  shadow holds data not yet applied

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high, sampled only on the rising clk edge.
- Reset values: slot_cnt=0, digit_idx=0, active and shadow value/dot/mask=0, update_pending=0, hex_out=0, dot_out=0, digit_en=0, frame_start=0. A reset asserted mid-slot forces all outputs to these values on the next edge.
- Slot timing:
  - slot_cnt counts 0..REFRESH_DIV-1 and then wraps to 0.
  - On the wrap, digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
- Phases within a slot:
  - BLANK when slot_cnt < BLANK_CYCLES: digit_en=0.
  - SHOW otherwise: digit_en = onehot(digit_idx) AND active_mask.
- Registered outputs: hex_out, dot_out, digit_en and frame_start are registered. Each edge loads them from the next-state slot_cnt/digit_idx/active values, so they are aligned with the state in the same cycle (no extra latency).
- hex_out = active_value nibble[digit_idx] and dot_out = active_dot[digit_idx] for the whole slot, including BLANK. Masked digits still present their nibble; only digit_en is suppressed.
- Load:
  - On a load edge, shadow <= {value_in, dot_in, digit_mask} and update_pending <= 1.
  - A second load while pending overwrites the shadow (last wins).
- Frame boundary edge (slot_cnt==REFRESH_DIV-1 and digit_idx==NUM_DIGITS-1):
  - digit_idx <= 0, slot_cnt <= 0, frame_start <= 1.
  - If load=1 on this edge: active <= inputs directly, update_pending stays 0.
  - Else if update_pending: active <= shadow, update_pending <= 0.
  - Otherwise active is unchanged.
- frame_start is 0 on all other edges. The first pulse occurs NUM_DIGITS*REFRESH_DIV cycles after reset release.
- Active values never change except at a frame boundary edge.

Decomposition:
- Package seg_scan_pkg:
  - localparam function for counter width, $clog2(REFRESH_DIV).
  - Phase enum {PH_BLANK, PH_SHOW}.
- Sub-module seg_slot_timer: slot_cnt/digit_idx counters. Outputs slot_last, frame_last and blank_phase.
- Top level holds the shadow/active registers and the output registers.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset held 3 cycles then released -> hex_out=0, digit_en=0000, update_pending=0. First frame_start pulse exactly 32 cycles after release.
2. load with value_in=16'h1A2F, dot_in=4'b0100, mask=4'b1111 -> update_pending=1 until the boundary. In the next frame:
   - digit 0 slot: cycles 0-1 digit_en=0000, hex_out=F; cycles 2-7 digit_en=0001.
   - digit 1 shows 2; digit 2 shows A with dot_out=1; digit 3 shows 1.
3. load 16'h0000 mid-frame (digit 2, slot_cnt 5) -> hex_out/dot/digit_en unchanged through the rest of the frame. New value from the next frame_start; update_pending clears on that same edge.
4. Two loads in one frame (16'h1111, then 16'h2222) -> next frame shows 2 on all digits; 1 is never displayed.
5. load 16'h5555 on the boundary edge itself -> the frame starting that edge shows 5 on all digits; update_pending stays 0.
6. mask=4'b1010 -> digit_en bits 0 and 2 never assert, while hex_out still cycles through all nibbles. Reset asserted during a SHOW phase -> next cycle digit_en=0000, hex_out=0.
